signal_engine_mac: RTL and testbench

- Parametrised next-generation signal generator.
- Computes the weighted sum of NUM_FEAT signed fixed-point features, signal = sat(sum_i feat_i * w_i), with runtime-programmable weights.
- Uses one shared multiplier iterated over features by an FSM; saturates the result to the data width.
- Sits between the feature pipeline (return/EMA/etc.) and downstream decision logic; valid/ready stream on both sides.

---
 rtl/signal_engine_mac.sv | 138 +++++++++++++
 tb/tb_signal_engine_mac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_engine_mac.sv
// Weighted-sum signal generator: signal = sat(sum feat_i * w_i), one shared multiplier stepped over the features.
// Latency: out_valid rises NUM_FEAT edges after the accepting edge; throughput one sample per NUM_FEAT+1 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready low while computing or holding an unconsumed result.
module signal_engine_mac #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int NUM_FEAT = 4,
    parameter int IDX_W    = $clog2(NUM_FEAT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_FEAT*DATA_W-1:0] feat_in,
    input  logic                       w_wr_en,
    input  logic [IDX_W-1:0]           w_wr_addr,
    input  logic [DATA_W-1:0]          w_wr_data,
    output logic                       w_wr_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          signal_out,
    output logic                       sat_out,
    output logic                       busy
);
    // The accumulator carries every bit of each shifted product (not just DATA_W of it),
    // so the final clip compares the exact sum and large terms cannot wrap.
    localparam int TERM_W = 2*DATA_W - FRAC_W;
    localparam int ACC_W  = TERM_W + $clog2(NUM_FEAT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_HOLD} state_t;

    state_t                      state, state_nxt;
    logic [NUM_FEAT*DATA_W-1:0]  feat_q;
    logic signed [DATA_W-1:0]    weight [NUM_FEAT];
    logic signed [ACC_W-1:0]     acc;
    logic [IDX_W-1:0]            idx;

    logic signed [DATA_W-1:0]    feat_cur;
    logic signed [DATA_W-1:0]    w_cur;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [TERM_W-1:0]    term;
    logic signed [ACC_W-1:0]     acc_sum;
    logic                        sat_hi, sat_lo;
    logic [DATA_W-1:0]           sat_val;
    logic                        accept;
    logic                        w_take;

    assign busy       = (state == S_MAC);
    assign out_valid  = (state == S_HOLD);
    assign w_wr_ready = !busy;
    assign accept     = in_valid && in_ready;
    assign w_take     = w_wr_en && w_wr_ready && (int'(w_wr_addr) < NUM_FEAT);

    // Shared multiplier: product of the current feature/weight, floor-shifted back to the Q format.
    assign feat_cur = feat_q[idx*DATA_W +: DATA_W];
    assign w_cur    = weight[idx];
    assign prod     = (2*DATA_W)'(feat_cur) * (2*DATA_W)'(w_cur);
    assign term     = prod[2*DATA_W-1:FRAC_W];
    assign acc_sum  = acc + ACC_W'(term);

    // Clip the running total to DATA_W on the final term.
    always_comb begin
        sat_hi  = (acc_sum > MAX_V);
        sat_lo  = (acc_sum < MIN_V);
        sat_val = acc_sum[DATA_W-1:0];
        if (sat_hi) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and in_ready; HOLD accepts a new sample on the same edge the result is consumed.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_MAC;
            end
            S_MAC: begin
                if (idx == LAST_IDX) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? S_MAC : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch sample on accept, accumulate one term per MAC cycle, register the clipped result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q     <= '0;
            acc        <= '0;
            idx        <= '0;
            signal_out <= '0;
            sat_out    <= 1'b0;
        end else if (accept) begin
            feat_q <= feat_in;
            acc    <= '0;
            idx    <= '0;
        end else if (state == S_MAC) begin
            acc <= acc_sum;
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
                signal_out <= sat_val;
                sat_out    <= sat_hi || sat_lo;
            end
        end
    end

    // Weight table: writes land whenever not computing; weights are only read during MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FEAT; i++) weight[i] <= '0;
        end else if (w_take) begin
            weight[w_wr_addr] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_signal_engine_mac.sv
// Self-checking bench for signal_engine_mac: directed vectors plus randomized samples against an arithmetic model.
// Latency: checks out_valid arrives exactly 4 edges after acceptance.
// Backpressure: exercises held results, same-cycle re-accept and writes blocked while busy.
module tb_signal_engine_mac;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*32-1:0] feat_in;
    logic          w_wr_en = 1'b0;
    logic [1:0]    w_wr_addr = '0;
    logic [31:0]   w_wr_data = '0;
    logic          w_wr_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   signal_out;
    logic          sat_out;
    logic          busy;

    logic [31:0]   fv [N];
    logic [31:0]   mw [N];
    int            checks = 0;
    int            errors = 0;

    assign feat_in = {fv[3], fv[2], fv[1], fv[0]};

    always #5 clk = ~clk;

    signal_engine_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .feat_in    (feat_in),
        .w_wr_en    (w_wr_en),
        .w_wr_addr  (w_wr_addr),
        .w_wr_data  (w_wr_data),
        .w_wr_ready (w_wr_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .signal_out (signal_out),
        .sat_out    (sat_out),
        .busy       (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact real-valued weighted sum with floor per term, then clip to 32-bit signed.
    task automatic model(output logic [31:0] ev, output logic es);
        longint s = 0;
        longint hi = (longint'(1) <<< 31) - 1;
        longint lo = -(longint'(1) <<< 31);
        for (int i = 0; i < N; i++)
            s += (longint'($signed(fv[i])) * longint'($signed(mw[i]))) >>> 16;
        es = 1'b0;
        ev = s[31:0];
        if (s > hi) begin
            ev = 32'h7FFF_FFFF; es = 1'b1;
        end else if (s < lo) begin
            ev = 32'h8000_0000; es = 1'b1;
        end
    endtask

    task automatic wr_weight(input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
        while (!w_wr_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("wr_rdy", w_wr_ready, 1);
        @(posedge clk); #1;
        w_wr_en = 1'b0;
        mw[a] = d;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, 4);
    endtask

    // Send fv (optionally with a weight write on the accepting edge), check result, stall, consume.
    task automatic send(input string tag, input bit do_wr, input logic [1:0] wa,
                        input logic [31:0] wd, input int stall);
        logic [31:0] ev;
        logic        es;
        int          n = 0;
        int          lat;
        if (do_wr) begin w_wr_en = 1'b1; w_wr_addr = wa; w_wr_data = wd; end
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "_acc"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (do_wr) begin w_wr_en = 1'b0; mw[wa] = wd; end
        model(ev, es);
        wait_result(tag, lat);
        check({tag, "_sig"}, signal_out, ev);
        check({tag, "_sat"}, sat_out, es);
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                check({tag, "_hold"}, signal_out, ev);
                check({tag, "_hold_ir"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_done"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] ev;
        logic        es;
        int          lat;
        for (int i = 0; i < N; i++) begin fv[i] = '0; mw[i] = '0; end

        // Reset state
        #12;
        check("rst_ov", out_valid, 0);
        check("rst_sig", signal_out, 0);
        check("rst_sat", sat_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ir", in_ready, 1);
        check("rst_wr", w_wr_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed Q16.16 vector
        wr_weight(0, 32'h0000_8000); wr_weight(1, 32'h0000_4000);
        wr_weight(2, 32'hFFFF_0000); wr_weight(3, 32'h0002_0000);
        fv[0] = 32'h0001_0000; fv[1] = 32'h0002_0000; fv[2] = 32'h0000_8000; fv[3] = 32'h0000_4000;
        send("spec", 0, 0, 0, 0);
        check("spec_const", signal_out, 32'h0001_0000);

        // Positive and negative saturation
        for (int i = 0; i < N; i++) begin wr_weight(2'(i), 32'h7FFF_0000); fv[i] = 32'h7FFF_0000; end
        send("satp", 0, 0, 0, 0);
        check("satp_const", signal_out, 32'h7FFF_FFFF);
        check("satp_flag", sat_out, 1);
        for (int i = 0; i < N; i++) wr_weight(2'(i), 32'h8000_0000);
        send("satn", 0, 0, 0, 0);
        check("satn_const", signal_out, 32'h8000_0000);
        check("satn_flag", sat_out, 1);

        // Floor on negative products
        wr_weight(0, 32'h0000_0001); wr_weight(1, 0); wr_weight(2, 0); wr_weight(3, 0);
        fv[0] = 32'hFFFF_0000; fv[1] = 32'h1234_5678; fv[2] = 32'h0BAD_F00D; fv[3] = 32'h7000_0000;
        send("trunc", 0, 0, 0, 0);
        check("trunc_const", signal_out, 32'hFFFF_FFFF);

        // Backpressure with a second sample waiting, then zero-bubble accept
        for (int i = 0; i < N; i++) begin wr_weight(2'(i), 32'h0001_0000 + 32'(i) * 32'h4000); fv[i] = 32'h0000_3000 * 32'(i + 1); end
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(ev, es);
        wait_result("bp1", lat);
        check("bp1_sig", signal_out, ev);
        fv[0] = 32'hFFFE_0000; fv[2] = 32'h0005_0000;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_stable", signal_out, ev);
            check("bp_ir", in_ready, 0);
            check("bp_ov", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ir_up", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_reacc_ov", out_valid, 0);
        check("bp_reacc_busy", busy, 1);
        model(ev, es);
        wait_result("bp2", lat);
        check("bp2_sig", signal_out, ev);
        @(posedge clk); #1;

        // Weight write held across a busy period
        fv[1] = 32'h0002_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_wr_en = 1'b1; w_wr_addr = 2'd1; w_wr_data = 32'hFFFD_0000;
        check("wb_rdy", w_wr_ready, 0);
        check("wb_busy", busy, 1);
        model(ev, es);
        wait_result("wb", lat);
        check("wb_old", signal_out, ev);
        check("wb_rdy_hold", w_wr_ready, 1);
        @(posedge clk); #1;
        w_wr_en = 1'b0;
        mw[1] = 32'hFFFD_0000;
        send("wb_new", 0, 0, 0, 0);

        // Randomized samples, optional same-edge weight writes and stalls
        for (int t = 0; t < 24; t++) begin
            logic [31:0] wd;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) fv[i] = $urandom();
                else begin
                    fv[i] = 32'($urandom_range(0, 32'h0003_FFFF));
                    if ($urandom_range(0, 1) == 1) fv[i] = -fv[i];
                end
            end
            wd = 32'($urandom_range(0, 32'h0004_0000));
            if ($urandom_range(0, 1) == 1) wd = -wd;
            if ($urandom_range(0, 5) == 0) wd = $urandom();
            send("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wd, $urandom_range(0, 3));
        end

        // Reset during MAC aborts the sample and clears the weights
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("ar_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_busy", busy, 0);
        for (int i = 0; i < N; i++) mw[i] = '0;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("ar_no_result", out_valid, 0);
        end
        fv[0] = 32'h0003_0000; fv[1] = 32'hFFF0_0000; fv[2] = 32'h7FFF_0000; fv[3] = 32'h0000_0001;
        send("post_rst", 0, 0, 0, 0);
        check("post_rst_const", signal_out, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
